// File: rtl/debug_slave_jtag_host.sv
// debug_slave_jtag_host: system-clock-domain host for the virtual-JTAG side of the
// Nios II debug slave. Each accepted command runs one fixed scan:
// update IR, capture DR, shift DR_WIDTH bits LSB first, update DR, then run-test-idle.
// Optional feature macro: DEBUG_JTAG_HOST_RTI_EN.
//   - Defined: the scan ends with one RTI tck period.
//   - Undefined: UDR returns straight to IDLE and vji_rti is tied low.
module debug_slave_jtag_host #(
  parameter int TCK_DIV  = 4,
  parameter int DR_WIDTH = 38
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_data,
  output logic                rsp_valid,
  output logic [DR_WIDTH-1:0] rsp_data,
  output logic [1:0]          rsp_ir,
  output logic                vji_tck,
  output logic                vji_tdi,
  output logic                vji_uir,
  output logic                vji_cdr,
  output logic                vji_sdr,
  output logic                vji_udr,
  output logic                vji_rti,
  output logic [1:0]          vji_ir_in,
  input  logic                vji_tdo,
  input  logic [1:0]          vji_ir_out
);

  localparam int HC_W  = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
  localparam int BIT_W = (DR_WIDTH > 1) ? $clog2(DR_WIDTH) : 1;
  localparam logic [HC_W-1:0]  HC_MAX  = HC_W'(TCK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_MAX = BIT_W'(DR_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    UIR,
    CDR,
    SDR,
    UDR,
    RTI
  } state_t;

  state_t              state_q, state_d;
  logic [HC_W-1:0]     hc_q, hc_d;
  logic                tck_q, tck_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [DR_WIDTH-1:0] data_q, data_d;
  logic [1:0]          ir_q, ir_d;
  logic [DR_WIDTH-1:0] cap_q, cap_d;
  logic [1:0]          ir_cap_q, ir_cap_d;
  logic [DR_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [1:0]          rsp_ir_q, rsp_ir_d;
  logic                rsp_valid_q, rsp_valid_d;

  // Last clk of a tck period (tck high, half counter at its top) and the clk where tck rises.
  logic period_end;
  logic tck_rise;

  assign period_end = (state_q != IDLE) && tck_q && (hc_q == HC_MAX);
  assign tck_rise   = (state_q != IDLE) && !tck_q && (hc_q == HC_MAX);

  // Next-state, tck generation, shift/capture and response logic.
  always_comb begin
    state_d     = state_q;
    hc_d        = hc_q;
    tck_d       = tck_q;
    bit_d       = bit_q;
    data_d      = data_q;
    ir_d        = ir_q;
    cap_d       = cap_q;
    ir_cap_d    = ir_cap_q;
    rsp_data_d  = rsp_data_q;
    rsp_ir_d    = rsp_ir_q;
    rsp_valid_d = 1'b0;

    if (state_q != IDLE) begin
      if (hc_q == HC_MAX) begin
        hc_d  = '0;
        tck_d = ~tck_q;
      end else begin
        hc_d = hc_q + HC_W'(1);
      end
    end

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          data_d  = cmd_data;
          ir_d    = cmd_ir;
          hc_d    = '0;
          tck_d   = 1'b0;
          state_d = UIR;
        end
      end
      UIR: begin
        if (tck_rise) begin
          ir_cap_d = vji_ir_out;
        end
        if (period_end) begin
          state_d = CDR;
        end
      end
      CDR: begin
        if (period_end) begin
          state_d = SDR;
        end
      end
      SDR: begin
        if (tck_rise) begin
          cap_d = {vji_tdo, cap_q[DR_WIDTH-1:1]};
        end
        if (period_end) begin
          if (bit_q == BIT_MAX) begin
            bit_d   = '0;
            state_d = UDR;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      UDR: begin
        if (period_end) begin
`ifdef DEBUG_JTAG_HOST_RTI_EN
          state_d = RTI;
`else
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_data_d  = cap_q;
          rsp_ir_d    = ir_cap_q;
`endif
        end
      end
`ifdef DEBUG_JTAG_HOST_RTI_EN
      RTI: begin
        if (period_end) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_data_d  = cap_q;
          rsp_ir_d    = ir_cap_q;
        end
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      hc_q        <= '0;
      tck_q       <= 1'b0;
      bit_q       <= '0;
      data_q      <= '0;
      ir_q        <= '0;
      cap_q       <= '0;
      ir_cap_q    <= '0;
      rsp_data_q  <= '0;
      rsp_ir_q    <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hc_q        <= hc_d;
      tck_q       <= tck_d;
      bit_q       <= bit_d;
      data_q      <= data_d;
      ir_q        <= ir_d;
      cap_q       <= cap_d;
      ir_cap_q    <= ir_cap_d;
      rsp_data_q  <= rsp_data_d;
      rsp_ir_q    <= rsp_ir_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  // Strobes decode straight from the state register, so they only move on period boundaries.
  assign cmd_ready = (state_q == IDLE);
  assign vji_uir   = (state_q == UIR);
  assign vji_cdr   = (state_q == CDR);
  assign vji_sdr   = (state_q == SDR);
  assign vji_udr   = (state_q == UDR);
`ifdef DEBUG_JTAG_HOST_RTI_EN
  assign vji_rti   = (state_q == RTI);
`else
  assign vji_rti   = 1'b0;
`endif
  assign vji_tck   = tck_q;
  assign vji_tdi   = (state_q == SDR) ? data_q[bit_q] : 1'b0;
  assign vji_ir_in = ir_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_ir    = rsp_ir_q;

endmodule

// File: tb/tb_debug_slave_jtag_host.sv
// tb_debug_slave_jtag_host: directed and randomized scans against a scan-level model
// (period sequence, latency formula, expected shifted-in data). A second instance
// with TCK_DIV=1 covers the fastest tck setting.
module tb_debug_slave_jtag_host;

  localparam int DW = 38;
  localparam int D0 = 2;
  localparam int D1 = 1;
`ifdef DEBUG_JTAG_HOST_RTI_EN
  localparam int N      = DW + 4;
  localparam bit RTI_ON = 1'b1;
`else
  localparam int N      = DW + 3;
  localparam bit RTI_ON = 1'b0;
`endif
  localparam int L0 = 1 + N * 2 * D0;
  localparam int L1 = 1 + N * 2 * D1;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          cmd_valid, cmd_valid1;
  logic [1:0]    cmd_ir;
  logic [DW-1:0] cmd_data;
  logic          tdo_mode;
  logic [1:0]    ir_out;

  logic          cmd_ready, rsp_valid;
  logic [DW-1:0] rsp_data;
  logic [1:0]    rsp_ir, vji_ir_in;
  logic          vji_tck, vji_tdi, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti, vji_tdo;

  logic          cmd_ready1, rsp_valid1;
  logic [DW-1:0] rsp_data1;
  logic [1:0]    rsp_ir1, ir_in1;
  logic          tck1, tdi1, uir1, cdr1, sdr1, udr1, rti1;

  // Slave emulation: tdo either loops back tdi or is tied high.
  assign vji_tdo = tdo_mode ? 1'b1 : vji_tdi;

  debug_slave_jtag_host #(.TCK_DIV(D0), .DR_WIDTH(DW)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ir(rsp_ir),
    .vji_tck(vji_tck), .vji_tdi(vji_tdi), .vji_uir(vji_uir), .vji_cdr(vji_cdr),
    .vji_sdr(vji_sdr), .vji_udr(vji_udr), .vji_rti(vji_rti), .vji_ir_in(vji_ir_in),
    .vji_tdo(vji_tdo), .vji_ir_out(ir_out)
  );

  debug_slave_jtag_host #(.TCK_DIV(D1), .DR_WIDTH(DW)) u_dut1 (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1), .cmd_ir(cmd_ir), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid1), .rsp_data(rsp_data1), .rsp_ir(rsp_ir1),
    .vji_tck(tck1), .vji_tdi(tdi1), .vji_uir(uir1), .vji_cdr(cdr1),
    .vji_sdr(sdr1), .vji_udr(udr1), .vji_rti(rti1), .vji_ir_in(ir_in1),
    .vji_tdo(tdi1), .vji_ir_out(ir_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: per tck rising edge records strobes, tdi and ir_in; flags tdi/ir_in moving while tck is high.
  logic [4:0] strobe_q[$];
  logic       tdi_q[$];
  logic [1:0] irin_q[$];
  int         rsp_cnt = 0;
  int         viol = 0;
  int         viol1 = 0;
  int         rises1 = 0;
  bit         rti_seen = 1'b0;
  logic       prev_tck = 1'b0, prev_tdi = 1'b0, prev_tck1 = 1'b0;
  logic [1:0] prev_irin = 2'b00;

  always @(negedge clk) begin
    if (vji_tck && !prev_tck) begin
      strobe_q.push_back({vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti});
      tdi_q.push_back(vji_tdi);
      irin_q.push_back(vji_ir_in);
    end
    if (vji_tck && (vji_tdi !== prev_tdi || vji_ir_in !== prev_irin)) viol++;
    if (rsp_valid) rsp_cnt++;
    if (vji_rti || rti1) rti_seen = 1'b1;
    if (tck1 && !prev_tck1) rises1++;
    if ((32'(uir1) + 32'(cdr1) + 32'(sdr1) + 32'(udr1) + 32'(rti1)) > 1) viol1++;
    prev_tck  = vji_tck;
    prev_tdi  = vji_tdi;
    prev_irin = vji_ir_in;
    prev_tck1 = tck1;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scan-level model: the k-th tck period of a scan and the tdi bit it must carry.
  function automatic logic [4:0] exp_strobe(input int k);
    if (k == 0) return 5'b10000;
    if (k == 1) return 5'b01000;
    if (k < 2 + DW) return 5'b00100;
    if (k == 2 + DW) return 5'b00010;
    return 5'b00001;
  endfunction

  function automatic logic exp_tdi(input int k, input logic [DW-1:0] d);
    if (k >= 2 && k < 2 + DW) return d[k-2];
    return 1'b0;
  endfunction

  task automatic applyStimulus(input logic [1:0] ir, input logic [DW-1:0] data,
                               output int acc, output int base);
    int i;
    i = 0;
    while (!cmd_ready && i < 4 * L0) begin
      @(negedge clk);
      i++;
    end
    chk("ready_before_cmd", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_ir    = ir;
    cmd_data  = data;
    acc       = cyc;
    base      = strobe_q.size();
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_ir    = 2'($urandom);
    cmd_data  = DW'({$urandom, $urandom});
  endtask

  task automatic checkOutput(input logic [1:0] ir, input logic [DW-1:0] data,
                             input logic [DW-1:0] exp_rsp, input logic [1:0] exp_rir,
                             input int acc, input int base);
    int i;
    logic [4:0] s;
    logic       t;
    logic [1:0] r;
    i = 0;
    while (!rsp_valid && i < 2 * L0) begin
      @(negedge clk);
      i++;
    end
    chk("rsp_seen", rsp_valid, 1);
    if (!rsp_valid) return;
    chk("latency", 64'(cyc - acc), 64'(L0));
    chk("rsp_data", rsp_data, exp_rsp);
    chk("rsp_ir", rsp_ir, exp_rir);
    chk("ready_at_rsp", cmd_ready, 1);
    chk("strobes_idle", {vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti}, 0);
    chk("tck_rises", 64'(strobe_q.size() - base), 64'(N));
    for (int k = 0; k < N; k++) begin
      if (base + k < strobe_q.size()) begin
        s = strobe_q[base+k];
        t = tdi_q[base+k];
        r = irin_q[base+k];
      end else begin
        s = 5'bx;
        t = 1'bx;
        r = 2'bx;
      end
      chk($sformatf("strobe[%0d]", k), s, exp_strobe(k));
      chk($sformatf("tdi[%0d]", k), t, exp_tdi(k, data));
      chk($sformatf("ir_in[%0d]", k), r, ir);
    end
    @(negedge clk);
    chk("rsp_pulse", rsp_valid, 0);
    chk("rsp_hold", rsp_data, exp_rsp);
    chk("tdi_ir_stable", 64'(viol), 0);
    chk("rti_seen", rti_seen, RTI_ON);
  endtask

  int            acc, base, acc2, cnt, sz, i0, r0;
  logic [1:0]    ir;
  logic [DW-1:0] data, data2;

  initial begin
    // Reset with random inputs.
    reset_n    = 1'b1;
    cmd_valid  = 1'($urandom);
    cmd_valid1 = 1'($urandom);
    cmd_ir     = 2'($urandom);
    cmd_data   = DW'({$urandom, $urandom});
    tdo_mode   = 1'($urandom);
    ir_out     = 2'($urandom);
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ready", cmd_ready, 1);
    chk("reset_outs", {rsp_valid, vji_tck, vji_tdi, vji_uir, vji_cdr, vji_sdr,
                       vji_udr, vji_rti, vji_ir_in, rsp_ir}, 0);
    chk("reset_rsp_data", rsp_data, 0);
    chk("reset_ready1", cmd_ready1, 1);
    cmd_valid  = 1'b0;
    cmd_valid1 = 1'b0;
    tdo_mode   = 1'b0;
    reset_n    = 1'b1;
    repeat (20) @(negedge clk);
    chk("idle_no_tck", 64'(strobe_q.size()), 0);
    chk("idle_ready", cmd_ready, 1);

    // Directed loopback.
    $display("[TB] loopback scan");
    ir_out = 2'b11;
    applyStimulus(2'b01, 38'h2A_5555_5555, acc, base);
    checkOutput(2'b01, 38'h2A_5555_5555, 38'h2A_5555_5555, 2'b11, acc, base);

    // Tied tdo and ir_out.
    $display("[TB] tied tdo scan");
    tdo_mode = 1'b1;
    ir_out   = 2'b10;
    applyStimulus(2'b10, '0, acc, base);
    checkOutput(2'b10, '0, '1, 2'b10, acc, base);
    tdo_mode = 1'b0;

    // Random loopback scans.
    for (int n = 0; n < 3; n++) begin
      ir     = 2'($urandom);
      data   = DW'({$urandom, $urandom});
      ir_out = 2'($urandom);
      @(negedge clk);
      applyStimulus(ir, data, acc, base);
      checkOutput(ir, data, data, ir_out, acc, base);
    end

    // Back-to-back with cmd_valid held high; the second command waits while busy.
    $display("[TB] back-to-back");
    ir     = 2'($urandom);
    data   = DW'({$urandom, $urandom});
    data2  = ~data;
    ir_out = 2'($urandom);
    @(negedge clk);
    applyStimulus(ir, data, acc, base);
    cmd_valid = 1'b1;
    cmd_ir    = ~ir;
    cmd_data  = data2;
    repeat (20) @(negedge clk);
    chk("ready_busy", cmd_ready, 0);
    checkOutput(ir, data, data, ir_out, acc, base);
    cmd_valid = 1'b0;
    acc2 = acc + L0;
    checkOutput(~ir, data2, data2, ir_out, acc2, base + N);

    // Reset abort at SDR bit 10.
    $display("[TB] reset abort");
    data = DW'({$urandom, $urandom});
    @(negedge clk);
    applyStimulus(2'b01, data, acc, base);
    i0 = 0;
    while ((strobe_q.size() - base) < 13 && i0 < 4 * L0) begin
      @(negedge clk);
      i0++;
    end
    chk("abort_in_sdr", vji_sdr, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_tck", vji_tck, 0);
    chk("abort_strobes", {vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti, vji_tdi}, 0);
    chk("abort_rsp_data", rsp_data, 0);
    chk("abort_ready", cmd_ready, 1);
    cnt = rsp_cnt;
    sz  = strobe_q.size();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (L0 + 20) @(negedge clk);
    chk("abort_no_rsp", 64'(rsp_cnt - cnt), 0);
    chk("abort_no_tck", 64'(strobe_q.size() - sz), 0);

    // TCK_DIV=1 instance, loopback.
    $display("[TB] tck_div=1 scans");
    for (int n = 0; n < 2; n++) begin
      ir     = 2'($urandom);
      data   = DW'({$urandom, $urandom});
      ir_out = 2'($urandom);
      @(negedge clk);
      cmd_valid1 = 1'b1;
      cmd_ir     = ir;
      cmd_data   = data;
      acc        = cyc;
      r0         = rises1;
      @(negedge clk);
      cmd_valid1 = 1'b0;
      cmd_data   = DW'({$urandom, $urandom});
      i0 = 0;
      while (!rsp_valid1 && i0 < 2 * L1) begin
        @(negedge clk);
        i0++;
      end
      chk("d1_rsp_seen", rsp_valid1, 1);
      chk("d1_latency", 64'(cyc - acc), 64'(L1));
      chk("d1_rsp_data", rsp_data1, data);
      chk("d1_rsp_ir", rsp_ir1, ir_out);
      chk("d1_rises", 64'(rises1 - r0), 64'(N));
      chk("d1_ir_in", ir_in1, ir);
    end
    chk("d1_onehot", 64'(viol1), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
